// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART controller blocks.
//   UART_DATA_W : width of one UART byte lane
//   arbState_t  : arbiter sequencing states
//                 IDLE (ready to accept a byte)
//                 SEND (load strobe to the transmitter)
//                 WAIT (transmitter frame in flight)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arbState_t;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Purely combinational round-robin search. The search starts at ptr+1,
// wraps modulo N and returns the first set request.
//   req   [N]  : request vector
//   ptr   [PW] : index of the most recent winner (lowest priority)
//   pick  [N]  : one-hot winner, zero when nothing requests
//   found [1]  : at least one request is set
// ---------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          found
);

    logic [PW-1:0] w_idx;

    // First set request after ptr, in wrap-around order
    always_comb begin
        pick  = '0;
        found = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = PW'((int'(ptr) + k) % N);
            if (!found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N byte-stream requesters with
// round-robin arbitration at packet granularity. A winner keeps the
// transmitter until it sends a byte flagged last, or until it stays idle
// for LOCK_TIMEOUT cycles (0 = never time out).
//   clk, nReset        : clock, asynchronous active-low reset
//   reqValid/reqLast[N]: per-requester byte pending / end of packet
//   reqData [N*8]      : per-requester byte, lane i at [8i+7:8i]
//   reqReady[N]        : one-hot acceptance strobe (combinational)
//   txData/txValid     : byte and one-cycle load strobe to the transmitter
//   txBusy             : transmitter frame in progress
//   grant [N]          : one-hot current owner, zero when unowned
//   locked             : an owner holds the transmitter between bytes
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic [N-1:0]               reqValid,
    input  logic [N*UART_DATA_W-1:0]   reqData,
    input  logic [N-1:0]               reqLast,
    output logic [N-1:0]               reqReady,
    output logic [UART_DATA_W-1:0]     txData,
    output logic                       txValid,
    input  logic                       txBusy,
    output logic [N-1:0]               grant,
    output logic                       locked
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'((LOCK_TIMEOUT > 0) ? (LOCK_TIMEOUT - 1) : 0);

    arbState_t               r_state;
    logic [PW-1:0]           r_ptr;
    logic [UART_DATA_W-1:0]  r_hold;
    logic                    r_hold_last;
    logic [TW-1:0]           r_timer;
    logic [N-1:0]            r_grant;
    logic                    r_locked;
    logic                    r_tx_valid;

    logic [N-1:0]            w_rr_pick;
    logic                    w_rr_found;
    logic [N-1:0]            w_cand;
    logic                    w_found;
    logic                    w_owner_valid;
    logic                    w_accept;
    logic [PW-1:0]           w_idx;
    logic [UART_DATA_W-1:0]  w_byte;
    logic                    w_count;
    logic                    w_release;

    uart_rr_pick #(.N(N)) u_pick (
        .req   (reqValid),
        .ptr   (r_ptr),
        .pick  (w_rr_pick),
        .found (w_rr_found)
    );

    assign w_owner_valid = |(r_grant & reqValid);

    // While locked only the owner may be served; otherwise the round-robin pick
    always_comb begin
        if (r_locked) begin
            w_cand  = r_grant & reqValid;
            w_found = w_owner_valid;
        end else begin
            w_cand  = w_rr_pick;
            w_found = w_rr_found;
        end
    end

    assign w_accept = (r_state == IDLE) && w_found && !txBusy;
    assign reqReady = w_accept ? w_cand : '0;

    // Binary index of the one-hot candidate (OR-reduction, no priority chain)
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = w_idx | (w_cand[i] ? PW'(i) : PW'(0));
        end
    end

    assign w_byte    = reqData[int'(w_idx) * UART_DATA_W +: UART_DATA_W];
    // The idle timer only advances while the owner has nothing to offer
    assign w_count   = (LOCK_TIMEOUT != 0) && (r_state == IDLE) && r_locked && !w_owner_valid;
    assign w_release = (r_state == WAIT) && !txBusy && r_hold_last;

    // Sequencer: accept -> one SEND cycle -> WAIT until the frame drains
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= IDLE;
            r_ptr       <= PW'(N - 1);
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_tx_valid  <= 1'b0;
        end else begin
            r_tx_valid <= w_accept;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hold      <= w_byte;
                        r_hold_last <= reqLast[w_idx];
                        r_ptr       <= w_idx;
                        r_state     <= SEND;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEND: r_state <= WAIT;
                WAIT: begin
                    if (!txBusy) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ownership: taken on accept, dropped after a last byte or an idle timeout.
    // ptr keeps the timed-out owner so it has lowest priority next round.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_grant  <= '0;
            r_locked <= 1'b0;
            r_timer  <= '0;
        end else if (w_accept) begin
            r_grant  <= w_cand;
            r_locked <= 1'b1;
            r_timer  <= '0;
        end else if (w_release) begin
            r_grant  <= '0;
            r_locked <= 1'b0;
        end else if (w_count) begin
            if (r_timer == TMAX) begin
                r_grant  <= '0;
                r_locked <= 1'b0;
                r_timer  <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end else begin
            r_timer <= r_timer;
        end
    end

    assign txData  = r_hold;
    assign txValid = r_tx_valid;
    assign grant   = r_grant;
    assign locked  = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed scenarios followed by a randomized phase. Requesters are byte
// queues; a transaction-level reference model decides, cycle by cycle, who
// must be accepted and what the transmitter must see.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int LT = 8;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txBusy;
    logic [3:0]  grant;
    logic        locked;

    always #5 clk = ~clk;

    // Simple transmitter: busy for frame_len cycles after each load strobe
    int   tx_cnt = 0;
    int   frame_len = 3;
    logic force_busy = 1'b0;
    assign txBusy = (tx_cnt != 0) || force_busy;
    always @(posedge clk) begin
        if (txValid) tx_cnt <= frame_len;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end

    uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LT)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqReady (reqReady),
        .txData   (txData),
        .txValid  (txValid),
        .txBusy   (txBusy),
        .grant    (grant),
        .locked   (locked)
    );

    // Requester byte queues: {last, data}
    logic [8:0] q[4][$];
    logic [3:0] gate;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;
    int pulses = 0;
    int accepts = 0;
    logic [3:0] obs_ready;
    logic [7:0] log_byte[$];
    logic [3:0] log_grant[$];
    int         log_cyc[$];

    // Reference model (transaction level)
    int         m_owner = -1;   // -1 = unowned
    int         m_last  = N - 1;
    bit         m_send  = 1'b0; // load strobe expected this cycle
    bit         m_wait  = 1'b0; // frame in flight
    logic [7:0] m_hold  = 8'h00;
    bit         m_hold_last = 1'b0;
    int         m_left  = LT;   // idle cycles the owner may still waste

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step_model();
        logic [3:0] exp_ready;
        logic [8:0] ent;
        int g;
        exp_ready = 4'b0;
        g = -1;
        obs_ready = reqReady;
        if (txValid) begin
            pulses++;
            log_byte.push_back(txData);
            log_grant.push_back(grant);
            log_cyc.push_back(cyc_n);
        end
        if (!nReset) begin
            m_owner = -1; m_last = N - 1; m_send = 1'b0; m_wait = 1'b0;
            m_hold = 8'h00; m_hold_last = 1'b0; m_left = LT;
        end else if (!m_send && !m_wait && !txBusy) begin
            if (m_owner >= 0) begin
                if (reqValid[m_owner]) g = m_owner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && reqValid[(m_last + k) % N]) g = (m_last + k) % N;
                end
            end
            if (g >= 0) exp_ready = 4'(1 << g);
        end
        chk("reqReady", 32'(reqReady), 32'(exp_ready));
        chk("txValid",  32'(txValid),  32'(m_send));
        chk("txData",   32'(txData),   32'(m_hold));
        chk("grant",    32'(grant),    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("locked",   32'(locked),   32'(m_owner >= 0));
        if (!nReset) begin
            m_send = 1'b0;
        end else if (g >= 0) begin
            ent = q[g].pop_front();
            m_hold = ent[7:0]; m_hold_last = ent[8];
            m_owner = g; m_last = g; m_left = LT; m_send = 1'b1;
            accepts++;
        end else if (m_send) begin
            m_send = 1'b0; m_wait = 1'b1;
        end else if (m_wait) begin
            if (!txBusy) begin
                m_wait = 1'b0;
                if (m_hold_last) m_owner = -1;
            end
        end else if (m_owner >= 0 && !reqValid[m_owner]) begin
            m_left--;
            if (m_left == 0) m_owner = -1;
        end
    endtask

    task automatic cyc();
        for (int i = 0; i < N; i++) begin
            if (gate[i] && q[i].size() > 0) begin
                reqValid[i]     = 1'b1;
                reqData[8*i+:8] = q[i][0][7:0];
                reqLast[i]      = q[i][0][8];
            end else begin
                reqValid[i]     = 1'b0;
                reqData[8*i+:8] = 8'($urandom);
                reqLast[i]      = 1'($urandom);
            end
        end
        @(negedge clk);
        step_model();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    function automatic bit all_quiet();
        return (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
               (q[3].size() == 0) && !m_send && !m_wait && !txBusy;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_quiet() && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (log_byte.size() < cnt && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        int p;
        int r;
        int len;
        gate = 4'b0; reqValid = 4'b0; reqData = 32'b0; reqLast = 4'b0;

        // Reset: all outputs zero
        repeat (3) cyc();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_txValid", 32'(txValid), 32'd0);
        nReset = 1'b1;

        // First grant: requesters 1 and 3, single-byte packets
        q[1].push_back({1'b1, 8'hA1});
        q[3].push_back({1'b1, 8'hB3});
        gate = 4'b1010;
        drain("t1_drain", 100);
        chk("t1_count", 32'(log_byte.size()), 32'd2);
        chk("t1_byte0", 32'(log_byte[0]), 32'hA1);
        chk("t1_grant0", 32'(log_grant[0]), 32'b0010);
        chk("t1_byte1", 32'(log_byte[1]), 32'hB3);
        chk("t1_grant1", 32'(log_grant[1]), 32'b1000);

        // Packet lock: requester 2 keeps the transmitter over requester 0
        base = log_byte.size();
        q[2].push_back({1'b0, 8'h41});
        q[2].push_back({1'b0, 8'h42});
        q[2].push_back({1'b1, 8'h43});
        q[0].push_back({1'b1, 8'h55});
        gate = 4'b0100;
        wait_log("t2_first", base + 1, 50);
        gate = 4'b0101;
        drain("t2_drain", 200);
        chk("t2_b0", 32'(log_byte[base]),   32'h41);
        chk("t2_b1", 32'(log_byte[base+1]), 32'h42);
        chk("t2_b2", 32'(log_byte[base+2]), 32'h43);
        chk("t2_b3", 32'(log_byte[base+3]), 32'h55);

        // Fairness: all four continuously valid, single-byte packets
        base = log_byte.size();
        for (int rq = 0; rq < 4; rq++)
            for (int j = 0; j < 3; j++)
                q[rq].push_back({1'b1, 4'(rq), 4'(j)});
        gate = 4'b1111;
        drain("t3_drain", 400);
        for (int k = 0; k < 12; k++) begin
            chk("t3_grant", 32'(log_grant[base+k]), 32'd1 << ((1 + k) % 4));
            chk("t3_byte", 32'(log_byte[base+k]), 32'(((1 + k) % 4) * 16 + k / 4));
        end

        // Timeout: owner 1 goes quiet, requester 3 waits
        base = log_byte.size();
        frame_len = 3;
        q[1].push_back({1'b0, 8'h10});
        gate = 4'b0010;
        wait_log("t4_first", base + 1, 50);
        q[3].push_back({1'b1, 8'h33});
        gate = 4'b1010;
        drain("t4_drain", 200);
        chk("t4_b0", 32'(log_byte[base]), 32'h10);
        chk("t4_b1", 32'(log_byte[base+1]), 32'h33);
        chk("t4_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd14);

        // Timeout race: owner reasserts on the last idle cycle of its lock
        base = log_byte.size();
        q[1].push_back({1'b0, 8'h20});
        gate = 4'b0010;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(m_owner == 1 && !m_send && !m_wait && m_left == 1) && n < 100);
        chk("t5_reach", 32'(n < 100), 32'd1);
        q[1].push_back({1'b1, 8'h21});
        cyc();
        chk("t5_ready", 32'(obs_ready), 32'b0010);
        chk("t5_locked", 32'(locked), 32'd1);
        drain("t5_drain", 100);
        chk("t5_b1", 32'(log_byte[base+1]), 32'h21);

        // txBusy high in IDLE blocks acceptance
        force_busy = 1'b1;
        q[0].push_back({1'b1, 8'h77});
        gate = 4'b0001;
        repeat (5) begin
            cyc();
            chk("t6_ready", 32'(obs_ready), 32'd0);
        end
        force_busy = 1'b0;
        drain("t6_drain", 100);
        chk("t6_byte", 32'(log_byte[log_byte.size()-1]), 32'h77);

        // Reset in the middle of a frame
        q[2].push_back({1'b1, 8'h99});
        gate = 4'b0100;
        n = 0;
        while (!m_wait && n < 50) begin
            cyc();
            n++;
        end
        chk("t7_reach", 32'(n < 50), 32'd1);
        p = pulses;
        nReset = 1'b0;
        cyc();
        chk("t7_grant", 32'(grant), 32'd0);
        chk("t7_locked", 32'(locked), 32'd0);
        chk("t7_txData", 32'(txData), 32'd0);
        cyc();
        nReset = 1'b1;
        repeat (8) cyc();
        chk("t7_no_extra", 32'(pulses), 32'(p));

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 3);
                if (q[r].size() < 6) begin
                    len = $urandom_range(1, 3);
                    for (int j = 0; j < len; j++) q[r].push_back({1'(j == len - 1), 8'($urandom)});
                end
            end
            for (int i = 0; i < N; i++) gate[i] = ($urandom_range(0, 3) != 0);
            frame_len = $urandom_range(1, 4);
            cyc();
        end
        gate = 4'b1111;
        drain("t8_drain", 3000);
        chk("pulses_vs_accepts", 32'(pulses), 32'(accepts));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
